// File: rtl/q_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : q_pkg
//  Description : Shared definitions for the Q-learning episode controller:
//                grid geometry, action encodings and the controller FSM
//                state type.
//  Revision    : 1.0  initial release
// ============================================================================
package q_pkg;

    // State word is {x, y}, one AXIS_W-bit coordinate per axis (8x8 grid)
    localparam int S_W    = 6;
    localparam int AXIS_W = S_W / 2;

    // Grid bounds on each axis
    localparam int GRID_MIN = 0;
    localparam int GRID_MAX = (1 << AXIS_W) - 1;

    // Action encodings
    localparam logic [1:0] ACT_LEFT  = 2'b00;   // y - 1
    localparam logic [1:0] ACT_UP    = 2'b01;   // x - 1
    localparam logic [1:0] ACT_RIGHT = 2'b10;   // y + 1
    localparam logic [1:0] ACT_DOWN  = 2'b11;   // x + 1

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } q_state_e;

endpackage : q_pkg
`default_nettype wire

// File: rtl/grid_next_state.sv
`default_nettype none
// ============================================================================
//  Module      : grid_next_state
//  Description : Combinational grid transition. Moves one cell in the
//                direction of the action; a move that would leave the grid
//                leaves the state unchanged.
//  Ports       : cur_i  [S_W]  current state {x, y}
//                act_i  [2]    action
//                next_o [S_W]  resulting state {x, y}
//  Revision    : 1.0  initial release
// ============================================================================
module grid_next_state #(
    parameter int S_W = q_pkg::S_W
) (
    input  logic [S_W-1:0] cur_i,
    input  logic [1:0]     act_i,
    output logic [S_W-1:0] next_o
);
    import q_pkg::*;

    localparam int AW = S_W / 2;

    localparam logic [AW-1:0] c_AXIS_MIN = '0;
    localparam logic [AW-1:0] c_AXIS_MAX = '1;

    logic [AW-1:0] w_x;
    logic [AW-1:0] w_y;
    logic [AW-1:0] w_nx;
    logic [AW-1:0] w_ny;

    always_comb begin
        w_x  = cur_i[S_W-1:AW];
        w_y  = cur_i[AW-1:0];
        w_nx = w_x;
        w_ny = w_y;
        case (act_i)
            ACT_LEFT:  if (w_y != c_AXIS_MIN) w_ny = w_y - AW'(1);
            ACT_UP:    if (w_x != c_AXIS_MIN) w_nx = w_x - AW'(1);
            ACT_RIGHT: if (w_y != c_AXIS_MAX) w_ny = w_y + AW'(1);
            ACT_DOWN:  if (w_x != c_AXIS_MAX) w_nx = w_x + AW'(1);
            default: begin
                w_nx = w_x;
                w_ny = w_y;
            end
        endcase
        next_o = {w_nx, w_ny};
    end

endmodule : grid_next_state
`default_nettype wire

// File: rtl/q_episode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : q_episode_ctrl
//  Description : Episode sequencer for a grid-world Q-learning engine.
//                Walks an agent from a start state, issuing one step per
//                accepted action, stalling actions whose {state, action}
//                Q entry is still being written back, and counting steps
//                and episodes until the configured number of episodes ends.
//  Ports       : clk, rst              clock, synchronous active-high reset
//                start                 begin a run (IDLE only)
//                cfg_*                 run configuration, latched on start
//                act_valid/act         action from the generator
//                act_ready             action consumed this cycle
//                step_valid/step_*     step issued to the Q datapath
//                busy                  run in progress (ISSUE or DRAIN)
//                done                  one-cycle pulse at run end
//                episode_cnt/step_cnt  progress counters
//  Revision    : 1.0  initial release
// ============================================================================
module q_episode_ctrl #(
    parameter int PIPE_LAT = 3,
    parameter int S_W      = q_pkg::S_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [S_W-1:0] cfg_start_state,
    input  logic [S_W-1:0] cfg_goal_state,
    input  logic [7:0]     cfg_max_steps,
    input  logic [7:0]     cfg_num_episodes,
    input  logic           act_valid,
    input  logic [1:0]     act,
    output logic           act_ready,
    output logic           step_valid,
    output logic [S_W-1:0] step_state,
    output logic [1:0]     step_action,
    output logic [S_W-1:0] step_next,
    output logic           busy,
    output logic           done,
    output logic [7:0]     episode_cnt,
    output logic [7:0]     step_cnt
);
    import q_pkg::*;

    q_state_e       state_q,    state_d;
    logic [S_W-1:0] cur_q,      cur_d;
    logic [7:0]     step_cnt_q, step_cnt_d;
    logic [7:0]     ep_cnt_q,   ep_cnt_d;
    logic           done_q;

    logic [S_W-1:0] cfg_start_q;
    logic [S_W-1:0] cfg_goal_q;
    logic [7:0]     cfg_max_q;
    logic [7:0]     cfg_neps_q;

    // Writeback hazard tracker: entry i holds the step fired i+1 cycles ago
    logic           trk_v_q [PIPE_LAT];
    logic [S_W-1:0] trk_s_q [PIPE_LAT];
    logic [1:0]     trk_a_q [PIPE_LAT];

    logic [S_W-1:0] w_next;
    logic           w_fire;
    logic           w_hazard;
    logic           w_drain_wait;
    logic [8:0]     w_cnt_inc;
    logic [8:0]     w_limit;

    grid_next_state #(
        .S_W (S_W)
    ) u_grid_next_state (
        .cur_i  (cur_q),
        .act_i  (act),
        .next_o (w_next)
    );

    // A max of 0 encodes 256 steps; widen to 9 bits so that case compares
    assign w_cnt_inc = {1'b0, step_cnt_q} + 9'd1;
    assign w_limit   = {(cfg_max_q == 8'd0), cfg_max_q};

    // The oldest entry retires on the same edge that leaves DRAIN, so only
    // the younger entries need to be empty for the tracker to be clear once
    // the episode count advances.
    always_comb begin
        w_hazard     = 1'b0;
        w_drain_wait = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            if (trk_v_q[i]) begin
                if (i < PIPE_LAT - 1) w_drain_wait = 1'b1;
                if ((trk_s_q[i] == cur_q) && (trk_a_q[i] == act)) w_hazard = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        step_cnt_d = step_cnt_q;
        ep_cnt_d   = ep_cnt_q;
        w_fire     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_d      = cfg_start_state;
                    step_cnt_d = '0;
                    ep_cnt_d   = '0;
                    state_d    = (cfg_num_episodes == 8'd0) ? ST_FIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_fire = act_valid & ~w_hazard;
                if (w_fire) begin
                    cur_d      = w_next;
                    step_cnt_d = step_cnt_q + 8'd1;
                    if ((w_next == cfg_goal_q) || (w_cnt_inc == w_limit)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!w_drain_wait) begin
                    ep_cnt_d = ep_cnt_q + 8'd1;
                    if (ep_cnt_d == cfg_neps_q) begin
                        state_d = ST_FIN;
                    end else begin
                        cur_d      = cfg_start_q;
                        step_cnt_d = '0;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            step_cnt_q  <= '0;
            ep_cnt_q    <= '0;
            done_q      <= 1'b0;
            cfg_start_q <= '0;
            cfg_goal_q  <= '0;
            cfg_max_q   <= '0;
            cfg_neps_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            step_cnt_q <= step_cnt_d;
            ep_cnt_q   <= ep_cnt_d;
            done_q     <= (state_q == ST_FIN);
            if ((state_q == ST_IDLE) && start) begin
                cfg_start_q <= cfg_start_state;
                cfg_goal_q  <= cfg_goal_state;
                cfg_max_q   <= cfg_max_steps;
                cfg_neps_q  <= cfg_num_episodes;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                trk_v_q[i] <= 1'b0;
                trk_s_q[i] <= '0;
                trk_a_q[i] <= '0;
            end
        end else begin
            trk_v_q[0] <= w_fire;
            trk_s_q[0] <= cur_q;
            trk_a_q[0] <= act;
            for (int i = 1; i < PIPE_LAT; i++) begin
                trk_v_q[i] <= trk_v_q[i-1];
                trk_s_q[i] <= trk_s_q[i-1];
                trk_a_q[i] <= trk_a_q[i-1];
            end
        end
    end

    // Step fields are gated so the datapath sees zeros between steps
    assign act_ready   = w_fire;
    assign step_valid  = w_fire;
    assign step_state  = w_fire ? cur_q  : '0;
    assign step_action = w_fire ? act    : '0;
    assign step_next   = w_fire ? w_next : '0;
    assign busy        = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done        = done_q;
    assign episode_cnt = ep_cnt_q;
    assign step_cnt    = step_cnt_q;

endmodule : q_episode_ctrl
`default_nettype wire

// File: tb/tb_q_episode_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_q_episode_ctrl
//  Description : Self-checking bench for q_episode_ctrl. A behavioural model
//                tracks agent position, step/episode counts, recent fires
//                (for the writeback hazard) and the run's timeline, and is
//                compared against the DUT every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_q_episode_ctrl;

    localparam int PIPE_LAT = 3;
    localparam int S_W      = 6;
    localparam int MAX_CYC  = 4000;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [S_W-1:0] cfg_start_state;
    logic [S_W-1:0] cfg_goal_state;
    logic [7:0]     cfg_max_steps;
    logic [7:0]     cfg_num_episodes;
    logic           act_valid;
    logic [1:0]     act;
    logic           act_ready;
    logic           step_valid;
    logic [S_W-1:0] step_state;
    logic [1:0]     step_action;
    logic [S_W-1:0] step_next;
    logic           busy;
    logic           done;
    logic [7:0]     episode_cnt;
    logic [7:0]     step_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    q_episode_ctrl #(
        .PIPE_LAT (PIPE_LAT),
        .S_W      (S_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cfg_start_state  (cfg_start_state),
        .cfg_goal_state   (cfg_goal_state),
        .cfg_max_steps    (cfg_max_steps),
        .cfg_num_episodes (cfg_num_episodes),
        .act_valid        (act_valid),
        .act              (act),
        .act_ready        (act_ready),
        .step_valid       (step_valid),
        .step_state       (step_state),
        .step_action      (step_action),
        .step_next        (step_next),
        .busy             (busy),
        .done             (done),
        .episode_cnt      (episode_cnt),
        .step_cnt         (step_cnt)
    );

    // Grid move on an 8x8 board, off-grid moves stay put
    function automatic int model_move(input int pos, input int a);
        int x, y;
        x = pos / 8;
        y = pos % 8;
        case (a)
            0: if (y > 0) y = y - 1;
            1: if (x > 0) x = x - 1;
            2: if (y < 7) y = y + 1;
            default: if (x < 7) x = x + 1;
        endcase
        return x * 8 + y;
    endfunction

    // Runs one complete run starting in the current cycle (caller is just
    // past a negedge) and checks the DUT against the model every cycle.
    // mode 0: act_valid=1 with fixed_act; mode 1: random actions.
    task automatic run_model(input int st, input int gl, input int mx, input int ne,
                             input int mode, input int fixed_act,
                             input bit poke_drain, input bit rnd_poke,
                             output int fires, output int dones);
        int c, issue_from, done_cycle, reload_cycle, drain_poke_at;
        int pos, steps, eps_done, eps_vis, lim, nxt, key;
        bit ended, hz, exp_fire, exp_busy;
        int hc[$];
        int hk[$];
        logic [S_W-1:0] v_st, v_gl;
        logic [7:0]     v_mx, v_ne;
        lim   = (mx == 0) ? 256 : mx;
        fires = 0;
        dones = 0;
        v_st = S_W'(st);
        v_gl = S_W'(gl);
        v_mx = 8'(mx);
        v_ne = 8'(ne);
        cfg_start_state  = v_st;
        cfg_goal_state   = v_gl;
        cfg_max_steps    = v_mx;
        cfg_num_episodes = v_ne;
        start     = 1'b1;
        act_valid = 1'b0;
        act       = 2'b00;
        #1;
        n_checks++;
        if (step_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL run_idle: step_valid=%b busy=%b required 0 0", step_valid, busy);
        end
        c = 0;
        issue_from    = 1;
        done_cycle    = (ne == 0) ? 2 : -1;
        reload_cycle  = -1;
        drain_poke_at = -1;
        pos = st; steps = 0; eps_done = 0; eps_vis = 0; ended = 0;
        forever begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (rnd_poke && (done_cycle < 0 || c < done_cycle) && $urandom_range(0, 7) == 0)
                start = 1'b1;
            if (poke_drain && c == drain_poke_at) start = 1'b1;
            if (mode == 0) begin
                act_valid = 1'b1;
                act       = 2'(fixed_act);
            end else begin
                act_valid = ($urandom_range(0, 3) != 0);
                act       = 2'($urandom_range(0, 3));
            end
            if (c == reload_cycle) begin
                eps_vis++;
                if (eps_done < ne) begin
                    pos = st; steps = 0; ended = 0; issue_from = c;
                end
            end
            #1;
            key = pos * 4 + int'(act);
            hz  = 0;
            foreach (hc[i]) if ((c - hc[i]) <= PIPE_LAT && hk[i] == key) hz = 1;
            exp_fire = (ne > 0) && !ended && (c >= issue_from) && act_valid && !hz;
            exp_busy = (ne > 0) && (c >= 1) && (done_cycle < 0 || c < done_cycle - 1);
            n_checks++;
            if (act_ready !== exp_fire || step_valid !== exp_fire) begin
                n_errors++;
                $display("FAIL fire c=%0d: act_ready=%b step_valid=%b required %b", c, act_ready, step_valid, exp_fire);
            end
            n_checks++;
            if (busy !== exp_busy) begin
                n_errors++;
                $display("FAIL busy c=%0d: got %b required %b", c, busy, exp_busy);
            end
            n_checks++;
            if (done !== (c == done_cycle)) begin
                n_errors++;
                $display("FAIL done c=%0d: got %b required %b", c, done, (c == done_cycle));
            end
            n_checks++;
            if (episode_cnt !== 8'(eps_vis) || step_cnt !== 8'(steps)) begin
                n_errors++;
                $display("FAIL counters c=%0d: episode_cnt=%0d step_cnt=%0d required %0d %0d", c, episode_cnt, step_cnt, eps_vis, steps);
            end
            if (done === 1'b1) dones++;
            if (exp_fire) begin
                nxt = model_move(pos, int'(act));
                n_checks++;
                if (step_state !== S_W'(pos) || step_action !== act || step_next !== S_W'(nxt)) begin
                    n_errors++;
                    $display("FAIL step c=%0d: state=%h action=%b next=%h required %h %b %h", c, step_state, step_action, step_next, pos, act, nxt);
                end
                fires++;
                hc.push_back(c);
                hk.push_back(key);
                pos = nxt;
                steps++;
                if (nxt == gl || steps == lim) begin
                    ended = 1;
                    eps_done++;
                    reload_cycle  = c + PIPE_LAT + 1;
                    drain_poke_at = c + 1;
                    if (eps_done == ne) done_cycle = c + PIPE_LAT + 2;
                end
            end
            while (hc.size() > 0 && (c - hc[0]) >= PIPE_LAT) begin
                void'(hc.pop_front());
                void'(hk.pop_front());
            end
            if (done_cycle >= 0 && c >= done_cycle + 1) break;
            if (c > MAX_CYC) begin
                n_checks++;
                n_errors++;
                $display("FAIL run_timeout: ran %0d cycles without done, required done", c);
                break;
            end
        end
        act_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; act_valid = 1'b0; act = 2'b00;
        cfg_start_state = '0; cfg_goal_state = 6'h01;
        cfg_max_steps = 8'd0; cfg_num_episodes = 8'd1;
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || step_valid !== 1'b0 || act_ready !== 1'b0 ||
            episode_cnt !== 8'd0 || step_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_state: busy=%b done=%b sv=%b ar=%b ep=%0d sc=%0d required all 0",
                     busy, done, step_valid, act_ready, episode_cnt, step_cnt);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_over_start: busy=%b required 0", busy);
        end
    endtask

    task automatic test_single_step();
        int f, d;
        run_model(6'h00, 6'h01, 0, 1, 0, 2, 1'b0, 1'b0, f, d);
        n_checks++;
        if (f != 1 || d != 1 || episode_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL single_step: fires=%0d dones=%0d ep=%0d required 1 1 1", f, d, episode_cnt);
        end
    endtask

    task automatic test_wall_hazard();
        int f, d;
        run_model(6'h00, 6'h3F, 3, 1, 0, 0, 1'b0, 1'b0, f, d);
        n_checks++;
        if (f != 3 || d != 1) begin
            n_errors++;
            $display("FAIL wall_hazard: fires=%0d dones=%0d required 3 1", f, d);
        end
    endtask

    task automatic test_step_limit();
        int f, d;
        run_model(6'h00, 6'h3F, 4, 2, 1, 0, 1'b0, 1'b0, f, d);
        n_checks++;
        if (f != 8 || d != 1 || episode_cnt !== 8'd2) begin
            n_errors++;
            $display("FAIL step_limit: fires=%0d dones=%0d ep=%0d required 8 1 2", f, d, episode_cnt);
        end
    endtask

    task automatic test_reset_midflight();
        int f, d;
        cfg_start_state = 6'h00; cfg_goal_state = 6'h3F;
        cfg_max_steps = 8'd0; cfg_num_episodes = 8'd1;
        start = 1'b1; act_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; act_valid = 1'b1; act = 2'b00;
        #1;
        n_checks++;
        if (step_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL midflight_fire1: step_valid=%b required 1", step_valid);
        end
        @(negedge clk);
        act = 2'b01;
        #1;
        n_checks++;
        if (step_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL midflight_fire2: step_valid=%b required 1", step_valid);
        end
        @(negedge clk);
        act_valid = 1'b0; rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b1 || step_cnt !== 8'd2) begin
            n_errors++;
            $display("FAIL midflight_pre: busy=%b step_cnt=%0d required 1 2", busy, step_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || step_valid !== 1'b0 || act_ready !== 1'b0 || done !== 1'b0 ||
            step_cnt !== 8'd0 || episode_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL midflight_reset: busy=%b sv=%b ar=%b done=%b sc=%0d ep=%0d required all 0",
                     busy, step_valid, act_ready, done, step_cnt, episode_cnt);
        end
        // Restart at once with the step fired 3 cycles ago; a stale tracker would stall it
        run_model(6'h00, 6'h3F, 1, 1, 0, 1, 1'b0, 1'b0, f, d);
        n_checks++;
        if (f != 1 || d != 1) begin
            n_errors++;
            $display("FAIL midflight_restart: fires=%0d dones=%0d required 1 1", f, d);
        end
    endtask

    task automatic test_zero_episodes();
        int f, d;
        run_model(6'h05, 6'h06, 3, 0, 0, 2, 1'b0, 1'b0, f, d);
        n_checks++;
        if (f != 0 || d != 1 || episode_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL zero_episodes: fires=%0d dones=%0d ep=%0d required 0 1 0", f, d, episode_cnt);
        end
    endtask

    task automatic test_start_in_drain();
        int f, d;
        run_model(6'h09, 6'h0A, 0, 2, 0, 2, 1'b1, 1'b0, f, d);
        n_checks++;
        if (f != 2 || d != 1 || episode_cnt !== 8'd2) begin
            n_errors++;
            $display("FAIL start_in_drain: fires=%0d dones=%0d ep=%0d required 2 1 2", f, d, episode_cnt);
        end
    endtask

    task automatic test_start_is_goal();
        int f, d;
        run_model(6'h12, 6'h12, 5, 2, 1, 0, 1'b0, 1'b0, f, d);
        n_checks++;
        if (f < 2 || d != 1 || episode_cnt !== 8'd2) begin
            n_errors++;
            $display("FAIL start_is_goal: fires=%0d dones=%0d ep=%0d required >=2 1 2", f, d, episode_cnt);
        end
    endtask

    task automatic test_random();
        int f, d, ne;
        for (int r = 0; r < 6; r++) begin
            ne = $urandom_range(0, 3);
            run_model($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 12),
                      ne, 1, 0, 1'b0, 1'b1, f, d);
            n_checks++;
            if (d != 1 || episode_cnt !== 8'(ne)) begin
                n_errors++;
                $display("FAIL random_run%0d: dones=%0d ep=%0d required 1 %0d", r, d, episode_cnt, ne);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_wall_hazard();
        test_step_limit();
        test_reset_midflight();
        test_zero_episodes();
        test_start_in_drain();
        test_start_is_goal();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_q_episode_ctrl
`default_nettype wire

// File: doc/q_episode_ctrl.md
Q_EPISODE_CTRL -- requirements
Module: q_episode_ctrl

Interface
REQ-001 The block SHALL have parameter PIPE_LAT, default 3, giving the cycles from step issue to Q/Qmax writeback.
REQ-002 The block SHALL have parameter S_W, default 6, giving the state width for an 8x8 grid (state[5:3]=x, state[2:0]=y).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  begins a run (sampled in IDLE only).
- cfg_start_state  in  S_W  initial state of each episode.
- cfg_goal_state  in  S_W  terminal state.
- cfg_max_steps  in  8  per-episode step limit; 0 means 256.
- cfg_num_episodes  in  8  episodes per run.
- act_valid  in  1  action generator has an action.
- act  in  2  action: 00 left (y-1), 01 up (x-1), 10 right (y+1), 11 down (x+1).
- act_ready  out  1  action consumed this cycle.
- step_valid  out  1  step issued to the datapath.
- step_state  out  S_W  current state of the issued step.
- step_action  out  2  action of the issued step.
- step_next  out  S_W  next state of the issued step.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run end.
- episode_cnt  out  8  episodes completed.
- step_cnt  out  8  steps issued in the current episode.

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, DRAIN and FIN; cfg_* SHALL be latched on start.
REQ-005 IDLE with start=1 SHALL load cur_state=cfg_start_state and clear both counters. It SHALL go to FIN if cfg_num_episodes==0, else to ISSUE.
REQ-006 Next state SHALL be computed combinationally from cur_state and act.
- A move off the grid edge (y=0 left, x=0 up, y=7 right, x=7 down) SHALL yield next=cur_state.
REQ-007 The fire condition SHALL be: ISSUE & act_valid & no hazard.
- In ISSUE, act_ready SHALL equal the fire condition.
- act_ready, step_valid and the step_* outputs SHALL be combinational in the same cycle.
REQ-008 On fire, cur_state SHALL become next and step_cnt SHALL increment.
REQ-009 The hazard tracker SHALL be a PIPE_LAT-entry shift register of {valid, state, action}.
- It SHALL shift every cycle.
- Entry 0 SHALL load the fired step, or valid=0 when no step fires.
REQ-010 A hazard SHALL exist when {cur_state, act} equals any valid tracker entry (read-after-write on the Q table).
REQ-011 The episode SHALL end on a fire where next==cfg_goal_state or step_cnt+1 reaches the limit; the FSM SHALL then go to DRAIN.
- Goal and limit in the same fire SHALL count as one episode end.
REQ-012 DRAIN SHALL wait until all tracker entries are invalid, then increment episode_cnt.
- If episode_cnt+1==cfg_num_episodes, the FSM SHALL go to FIN.
- Otherwise it SHALL reload cur_state=cfg_start_state, clear step_cnt and return to ISSUE.
REQ-013 FIN SHALL assert done for exactly one cycle, then go to IDLE; episode_cnt SHALL hold its value until the next start.
REQ-014 busy SHALL be 1 in ISSUE and DRAIN, and 0 in IDLE and FIN.
REQ-015 start outside IDLE SHALL be ignored.
REQ-016 cfg_start_state==cfg_goal_state SHALL still issue one step per episode.

Reset
REQ-017 rst SHALL return the FSM to IDLE mid-operation, clear every tracker valid bit, and drive all outputs to 0 on the next edge.
REQ-018 rst SHALL override start in the same cycle.

Structure
REQ-019 Shared package q_pkg SHALL hold the action encodings, S_W, grid bounds and the FSM state enum.
REQ-020 Next-state logic SHALL be the sub-module grid_next_state (combinational).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Start 0x00, goal 0x01, act=10 -> one step_valid (state 0x00, next 0x01), DRAIN for 3 cycles, done pulse, episode_cnt=1.
- State 0x00, act=00 -> step_next=0x00 (wall); repeated act=00 gives a hazard stall, so act_ready=0 for 3 cycles between issues.
- cfg_max_steps=4, goal unreachable, 2 episodes -> 4 steps each, step_cnt clears between episodes, done once with episode_cnt=2.
- rst asserted in ISSUE with 2 steps in flight -> next cycle busy=0, step_valid=0, tracker empty, and a new start succeeds.
- cfg_num_episodes=0 -> no step_valid, done 2 cycles after start.
- start pulsed during DRAIN -> ignored; the run completes normally.
